// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
//   Instruction fetch sequencer. It issues one outstanding fetch at a time,
//   holds the fetched word for decode until it is accepted, and handles
//   exception / jump / branch redirects. A fetch that is still in flight when
//   a redirect arrives is drained, and its data is dropped.
//
// Parameters
//   RESET_VECTOR : first fetch address after reset
//   EXC_VECTOR   : exception redirect address
//
// Optional feature
//   PC_SEQ_ALIGN_CHECK_EN : when defined, a misaligned jump or branch target
//                           redirects to EXC_VECTOR and pulses misalign_err.
//                           When undefined, the low two target bits are
//                           cleared and misalign_err stays 0.
//
// Ports
//   clk, reset            : clock, asynchronous active-low reset
//   imem_req/addr         : fetch request; held until imem_ack
//   imem_ack/rdata        : fetch completion and instruction word
//   instr/instr_pc/valid  : instruction presented to decode
//   instr_ready           : decode accepts instr
//   branch_taken/target   : branch redirect
//   jump/jump_target      : jump redirect
//   exc                   : exception redirect (highest priority)
//   pc                    : next address to be fetched
//   misalign_err          : one-cycle pulse on a misaligned redirect target
// ----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exc,
    output logic [31:0] pc,
    output logic        misalign_err
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t      state;
    logic [31:0] fetch_addr;

    logic        redirect;
    logic        bad_target;
    logic [31:0] raw_target;
    logic [31:0] redirect_pc;
    logic [31:0] next_pc;

    // Redirect target selection: exc > jump > branch_taken.
    always_comb begin
        redirect   = exc | jump | branch_taken;
        raw_target = jump ? jump_target : branch_target;
        bad_target = 1'b0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
        bad_target  = !exc && (jump || branch_taken) && (raw_target[1:0] != 2'b00);
        redirect_pc = (exc || bad_target) ? EXC_VECTOR : raw_target;
`else
        redirect_pc = exc ? EXC_VECTOR : (raw_target & ~32'h3);
`endif
        next_pc = redirect ? redirect_pc : pc;
    end

    assign imem_addr = fetch_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            pc           <= RESET_VECTOR;
            fetch_addr   <= RESET_VECTOR;
            imem_req     <= 1'b0;
            instr_valid  <= 1'b0;
            instr        <= 32'h0;
            instr_pc     <= 32'h0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redirect & bad_target;
            case (state)
                IDLE: begin
                    // Any imem_ack seen here belongs to an abandoned request.
                    state       <= FETCH;
                    imem_req    <= 1'b1;
                    instr_valid <= 1'b0;
                    pc          <= next_pc;
                    fetch_addr  <= next_pc;
                end
                FETCH: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            // Data belongs to the old path; refetch at target.
                            pc         <= next_pc;
                            fetch_addr <= next_pc;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= fetch_addr;
                            instr_valid <= 1'b1;
                            pc          <= pc + 32'd4;
                            imem_req    <= 1'b0;
                            state       <= HOLD;
                        end
                    end else if (redirect) begin
                        // Request must stay stable until acked, so drain it.
                        pc    <= next_pc;
                        state <= DRAIN;
                    end
                end
                HOLD: begin
                    // A redirect drops the held instruction even if decode
                    // accepted it in the same cycle.
                    if (redirect || instr_ready) begin
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        pc          <= next_pc;
                        fetch_addr  <= next_pc;
                        state       <= FETCH;
                    end
                end
                DRAIN: begin
                    // Later redirects only update pc; the ack completes the
                    // stale request and the next fetch uses the newest pc.
                    pc <= next_pc;
                    if (imem_ack) begin
                        fetch_addr <= next_pc;
                        state      <= FETCH;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam logic [31:0] EXC = 32'h8000_0180;

    logic        clk;
    logic        reset;
    logic        imem_req, imem_ack, instr_valid, instr_ready;
    logic [31:0] imem_addr, imem_rdata, instr, instr_pc, pc;
    logic        branch_taken, jump, exc, misalign_err;
    logic [31:0] branch_target, jump_target;

    // second instance: wrap-around reset vector
    logic        b_reset, b_req, b_ack, b_vld, b_err;
    logic [31:0] b_addr, b_rdata, b_instr, b_ipc, b_pc;

    int n_vec = 0;
    int n_bad = 0;

    pc_sequencer dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .exc(exc), .pc(pc), .misalign_err(misalign_err)
    );

    pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .reset(b_reset),
        .imem_req(b_req), .imem_addr(b_addr),
        .imem_ack(b_ack), .imem_rdata(b_rdata),
        .instr(b_instr), .instr_pc(b_ipc), .instr_valid(b_vld),
        .instr_ready(1'b1),
        .branch_taken(1'b0), .branch_target(32'h0),
        .jump(1'b0), .jump_target(32'h0),
        .exc(1'b0), .pc(b_pc), .misalign_err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        jmp;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt;
        logic        ex;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic [31:0] e_pc;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(input logic ack, input logic [31:0] rdata, input logic rdy,
                                input logic jmp, input logic [31:0] jt,
                                input logic br, input logic [31:0] bt, input logic ex,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_vld, input logic [31:0] e_instr,
                                input logic [31:0] e_ipc, input logic [31:0] e_pc,
                                input logic e_err);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.rdy = rdy;
        v.jmp = jmp; v.jt = jt; v.br = br; v.bt = bt; v.ex = ex;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld;
        v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_pc = e_pc; v.e_err = e_err;
        return v;
    endfunction

    task automatic idle_inputs();
        imem_ack = 0; imem_rdata = 0; instr_ready = 0;
        jump = 0; jump_target = 0; branch_taken = 0; branch_target = 0; exc = 0;
    endtask

    // ---------------- reference model (transaction view) ----------------
    bit          m_started, m_req, m_discard, m_valid, m_err;
    logic [31:0] m_pc, m_faddr, m_instr, m_ipc;

    function automatic logic [31:0] target_of(input bit ex, input bit jmp, input logic [31:0] jt,
                                              input logic [31:0] bt, output bit bad);
        logic [31:0] raw;
        bad = 0;
        if (ex) return EXC;
        raw = jmp ? jt : bt;
`ifdef PC_SEQ_ALIGN_CHECK_EN
        if (raw % 4 != 0) begin
            bad = 1;
            return EXC;
        end
        return raw;
`else
        return raw - (raw % 4);
`endif
    endfunction

    task automatic model_reset();
        m_started = 0; m_req = 0; m_discard = 0; m_valid = 0; m_err = 0;
        m_pc = 0; m_faddr = 0; m_instr = 0; m_ipc = 0;
    endtask

    task automatic model_step(input bit ack, input logic [31:0] rdata, input bit rdy,
                              input bit ex, input bit jmp, input logic [31:0] jt,
                              input bit br, input logic [31:0] bt);
        bit redir, bad;
        logic [31:0] tgt;
        redir = ex || jmp || br;
        tgt   = target_of(ex, jmp, jt, bt, bad);
        m_err = redir && bad;
        if (!m_started) begin
            m_started = 1;
            if (redir) m_pc = tgt;
            m_faddr = m_pc; m_req = 1;
        end else if (m_valid) begin
            if (redir || rdy) begin
                m_valid = 0;
                if (redir) m_pc = tgt;
                m_faddr = m_pc; m_req = 1;
            end
        end else if (ack) begin
            if (m_discard || redir) begin
                m_discard = 0;
                if (redir) m_pc = tgt;
                m_faddr = m_pc;
            end else begin
                m_instr = rdata; m_ipc = m_faddr; m_valid = 1; m_req = 0;
                m_pc = m_pc + 32'd4;
            end
        end else if (redir) begin
            m_discard = 1;
            m_pc = tgt;
        end
    endtask

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        t = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 3) == 0) t = t | 32'($urandom_range(1, 3));
        return t;
    endfunction

    vec_t tbl[22];
    localparam logic [31:0] A0 = 32'hA000_0000, A1 = 32'hA111_1111, A2 = 32'hA222_2222;
    localparam logic [31:0] B0 = 32'hB000_0000, C0 = 32'hC000_0000;

    initial begin
        logic [31:0] t20;
        logic        e20;
`ifdef PC_SEQ_ALIGN_CHECK_EN
        t20 = EXC;      e20 = 1'b1;
`else
        t20 = 32'h100;  e20 = 1'b0;
`endif
        //             ack rdata  rdy jmp jt      br bt      ex | req addr          vld instr ipc          pc            err
        tbl[0]  = mk(0, 0,     1, 0, 0,      0, 0,      0,  1, 32'h0,        0, 0,  0,            32'h0,        0);
        tbl[1]  = mk(0, 0,     1, 0, 0,      0, 0,      0,  1, 32'h0,        0, 0,  0,            32'h0,        0);
        tbl[2]  = mk(1, A0,    1, 0, 0,      0, 0,      0,  0, 0,            1, A0, 32'h0,        32'h4,        0);
        tbl[3]  = mk(0, 0,     1, 0, 0,      0, 0,      0,  1, 32'h4,        0, 0,  0,            32'h4,        0);
        tbl[4]  = mk(0, 0,     1, 0, 0,      0, 0,      0,  1, 32'h4,        0, 0,  0,            32'h4,        0);
        tbl[5]  = mk(1, A1,    1, 0, 0,      0, 0,      0,  0, 0,            1, A1, 32'h4,        32'h8,        0);
        tbl[6]  = mk(0, 0,     1, 0, 0,      0, 0,      0,  1, 32'h8,        0, 0,  0,            32'h8,        0);
        tbl[7]  = mk(0, 0,     1, 0, 0,      0, 0,      0,  1, 32'h8,        0, 0,  0,            32'h8,        0);
        tbl[8]  = mk(1, A2,    0, 0, 0,      0, 0,      0,  0, 0,            1, A2, 32'h8,        32'hC,        0);
        for (int i = 9; i <= 13; i++)
            tbl[i] = mk(0, 0,  0, 0, 0,      0, 0,      0,  0, 0,            1, A2, 32'h8,        32'hC,        0);
        tbl[14] = mk(0, 0,     1, 0, 0,      0, 0,      0,  1, 32'hC,        0, 0,  0,            32'hC,        0);
        tbl[15] = mk(0, 0,     0, 1, 32'h100, 1, 32'h200, 0, 1, 32'hC,        0, 0,  0,            32'h100,      0);
        tbl[16] = mk(1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0,   0,  1, 32'h100,      0, 0,  0,            32'h100,      0);
        tbl[17] = mk(1, B0,    0, 0, 0,      0, 0,      0,  0, 0,            1, B0, 32'h100,      32'h104,      0);
        tbl[18] = mk(0, 0,     0, 1, 32'h300, 0, 0,     1,  1, EXC,          0, 0,  0,            EXC,          0);
        tbl[19] = mk(1, C0,    0, 0, 0,      0, 0,      0,  0, 0,            1, C0, EXC,          EXC + 32'h4,  0);
        tbl[20] = mk(0, 0,     0, 1, 32'h102, 0, 0,     0,  1, t20,          0, 0,  0,            t20,          e20);
        tbl[21] = mk(0, 0,     0, 0, 0,      0, 0,      0,  1, t20,          0, 0,  0,            t20,          0);

        idle_inputs();
        reset = 0; b_reset = 0; b_ack = 0; b_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",   {31'b0, imem_req},     0);
        chk("rst_vld",   {31'b0, instr_valid},  0);
        chk("rst_instr", instr,                 0);
        chk("rst_ipc",   instr_pc,              0);
        chk("rst_pc",    pc,                    32'h0);
        chk("rst_err",   {31'b0, misalign_err}, 0);
        chk("b_rst_pc",  b_pc,                  32'hFFFF_FFFC);

        // wrap-around instance
        b_reset = 1;
        @(posedge clk); #1;
        chk("b_req1",  {31'b0, b_req}, 1);
        chk("b_addr1", b_addr, 32'hFFFF_FFFC);
        b_ack = 1; b_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        b_ack = 0;
        chk("b_vld",  {31'b0, b_vld}, 1);
        chk("b_ipc",  b_ipc, 32'hFFFF_FFFC);
        chk("b_pcwrap", b_pc, 32'h0);
        @(posedge clk); #1;
        chk("b_req2",  {31'b0, b_req}, 1);
        chk("b_addr2", b_addr, 32'h0);
        b_reset = 0;

        // directed table on main instance
        reset = 1;
        for (int i = 0; i < 22; i++) begin
            imem_ack = tbl[i].ack; imem_rdata = tbl[i].rdata; instr_ready = tbl[i].rdy;
            jump = tbl[i].jmp; jump_target = tbl[i].jt;
            branch_taken = tbl[i].br; branch_target = tbl[i].bt; exc = tbl[i].ex;
            @(posedge clk); #1;
            chk($sformatf("t%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
            if (tbl[i].e_req) chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("t%0d_vld", i), {31'b0, instr_valid}, {31'b0, tbl[i].e_vld});
            if (tbl[i].e_vld) begin
                chk($sformatf("t%0d_instr", i), instr, tbl[i].e_instr);
                chk($sformatf("t%0d_ipc", i), instr_pc, tbl[i].e_ipc);
            end
            chk($sformatf("t%0d_pc", i), pc, tbl[i].e_pc);
            chk($sformatf("t%0d_err", i), {31'b0, misalign_err}, {31'b0, tbl[i].e_err});
        end
        idle_inputs();

        // reset while a fetch is outstanding
        reset = 0;
        #1;
        chk("mid_rst_req", {31'b0, imem_req}, 0);
        chk("mid_rst_pc",  pc, 32'h0);
        imem_ack = 1; imem_rdata = 32'hEEEE_0001;
        @(posedge clk); #1;
        reset = 1;
        chk("idle_req", {31'b0, imem_req}, 0);
        @(posedge clk); #1;
        chk("post_idle_req",  {31'b0, imem_req}, 1);
        chk("post_idle_addr", imem_addr, 32'h0);
        chk("post_idle_vld",  {31'b0, instr_valid}, 0);
        @(posedge clk); #1;
        chk("post_idle_fetch", {31'b0, instr_valid}, 1);
        chk("post_idle_instr", instr, 32'hEEEE_0001);
        idle_inputs();

        // randomized run against the model
        reset = 0;
        @(posedge clk); #1;
        reset = 1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            instr_ready   = ($urandom_range(0, 3) != 0);
            exc           = ($urandom_range(0, 24) == 0);
            jump          = ($urandom_range(0, 11) == 0);
            branch_taken  = ($urandom_range(0, 9) == 0);
            jump_target   = rand_tgt();
            branch_target = rand_tgt();
            imem_ack      = m_req && ($urandom_range(0, 2) == 0);
            imem_rdata    = $urandom;
            @(posedge clk);
            model_step(imem_ack, imem_rdata, instr_ready, exc, jump, jump_target,
                       branch_taken, branch_target);
            #1;
            chk("r_req", {31'b0, imem_req}, {31'b0, m_req});
            if (m_req) chk("r_addr", imem_addr, m_faddr);
            chk("r_vld",   {31'b0, instr_valid}, {31'b0, m_valid});
            chk("r_instr", instr, m_instr);
            chk("r_ipc",   instr_pc, m_ipc);
            chk("r_pc",    pc, m_pc);
            chk("r_err",   {31'b0, misalign_err}, {31'b0, m_err});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'h8000_0180, the exception redirect address.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_req  output  1  fetch request, held high until imem_ack.
REQ-006 SHALL have port imem_addr  output  32  fetch address, stable while imem_req is high.
REQ-007 SHALL have port imem_ack  input  1  fetch complete; imem_rdata is valid in the same cycle.
REQ-008 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-009 SHALL have port instr  output  32  instruction presented to decode.
REQ-010 SHALL have port instr_pc  output  32  address of instr.
REQ-011 SHALL have port instr_valid  output  1  instr and instr_pc are valid.
REQ-012 SHALL have port instr_ready  input  1  decode accepts instr this cycle.
REQ-013 SHALL have ports branch_taken  input  1 and branch_target  input  32  branch redirect.
REQ-014 SHALL have ports jump  input  1 and jump_target  input  32  jump redirect.
REQ-015 SHALL have port exc  input  1  exception redirect to EXC_VECTOR.
REQ-016 SHALL have port pc  output  32  next address to be fetched.
REQ-017 SHALL have port misalign_err  output  1  one-cycle pulse when a redirect target is misaligned.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, HOLD, DRAIN; IDLE lasts one cycle after reset deassertion and then goes to FETCH.
REQ-019 In FETCH and DRAIN, SHALL drive imem_req=1 with imem_addr taken from an internal fetch_addr register; imem_req SHALL be 0 in IDLE and HOLD.
REQ-020 On entering FETCH, fetch_addr SHALL load pc.
REQ-021 In FETCH, on imem_ack with no redirect, SHALL:
- capture instr=imem_rdata and instr_pc=fetch_addr;
- set instr_valid=1 and pc=pc+4;
- go to HOLD.
REQ-022 In HOLD, instr_valid SHALL stay 1 and instr/instr_pc SHALL stay stable until instr_ready=1; then instr_valid SHALL go to 0 and the FSM SHALL go to FETCH (minimum 2 cycles per instruction).
REQ-023 A redirect is any of exc, jump, or branch_taken high; priority SHALL be exc > jump > branch_taken, and the winning target SHALL load pc on that edge.
REQ-024 Redirect handling by state:
- IDLE or HOLD: SHALL clear instr_valid and go to FETCH.
- FETCH with imem_ack in the same cycle: SHALL discard imem_rdata and go to FETCH.
- FETCH without imem_ack: SHALL go to DRAIN.
REQ-025 In DRAIN, SHALL hold the old fetch_addr request until imem_ack, discard the data, then go to FETCH; a further redirect in DRAIN SHALL overwrite pc and remain in DRAIN.
REQ-026 A redirect in HOLD coincident with instr_ready SHALL still drop the held instruction; decode SHALL treat it as consumed.
REQ-027 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-028 instr_valid SHALL never be 1 in FETCH, DRAIN, or IDLE.

Reset
REQ-029 While reset=0, SHALL asynchronously force:
- state=IDLE, pc=RESET_VECTOR, fetch_addr=RESET_VECTOR;
- imem_req=0, instr_valid=0, instr=0, instr_pc=0, misalign_err=0.
REQ-030 Reset asserted mid-fetch SHALL abandon the request; an imem_ack arriving in IDLE SHALL be ignored.

Configuration
REQ-031 With PC_SEQ_ALIGN_CHECK_EN defined, a jump or branch target with target[1:0]!=0 SHALL:
- load pc=EXC_VECTOR instead of the target;
- pulse misalign_err for one cycle;
- follow the normal redirect state handling.
REQ-032 Without PC_SEQ_ALIGN_CHECK_EN, target[1:0] SHALL be forced to 2'b00 on load and misalign_err SHALL be tied to 0.

Verification
REQ-033 Release reset, ack every request 1 cycle later, hold instr_ready=1 -> instr_pc sequence 0x0, 0x4, 0x8, each with instr_valid for exactly one cycle.
REQ-034 Hold instr_ready=0 for 5 cycles in HOLD -> instr/instr_pc stable, imem_req=0, pc unchanged.
REQ-035 Assert jump (jump_target=0x100) and branch_taken (branch_target=0x200) in FETCH 1 cycle before ack -> DRAIN; first ack data discarded; next imem_addr=0x100.
REQ-036 Assert exc and jump together in HOLD -> instr_valid=0 next cycle; next fetch address 0x8000_0180.
REQ-037 With the macro defined, jump_target=0x102 -> misalign_err one-cycle pulse and next fetch at EXC_VECTOR; without the macro, next fetch at 0x100.
REQ-038 Set RESET_VECTOR=0xFFFF_FFFC and fetch twice -> second imem_addr=0x0; assert reset mid-FETCH -> imem_req=0 immediately, one cycle in IDLE after release.
